// File: rtl/led_blink_if.sv
// Blink-driver handshake: event/level requests in, LED drive and queue status out.
// The request strobe is named evt because "event" is a reserved word.
interface led_blink_if #(
  parameter int unsigned PEND_WIDTH = 4
);
  logic                  evt;
  logic                  level;
  logic                  led_n;
  logic                  busy;
  logic [PEND_WIDTH-1:0] pending;
  logic                  overflow;

  modport master (output evt, level, input led_n, busy, pending, overflow);
  modport slave  (input evt, level, output led_n, busy, pending, overflow);
endinterface

// File: rtl/led_blink_driver.sv
// Turns one-cycle event strobes into fixed-length blinks on an active-low LED,
// queueing events that arrive mid-blink in a saturating counter.
module led_blink_driver #(
  parameter int unsigned ON_CYCLES  = 50000,
  parameter int unsigned OFF_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned PEND_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  led_blink_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0]  ON_LOAD  = CNT_WIDTH'(ON_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  OFF_LOAD = CNT_WIDTH'(OFF_CYCLES - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  timer_q, timer_d;
  logic [PEND_WIDTH-1:0] pend_q,  pend_d;
  logic                  led_n_q, led_n_d;
  logic                  busy_q,  busy_d;
  logic                  ovf_q,   ovf_d;
  logic                  pend_inc;
  logic                  pend_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      led_n_q <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      led_n_q <= led_n_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pend_d   = pend_q;
    led_n_d  = led_n_q;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
    pend_inc = 1'b0;
    pend_dec = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        led_n_d = ~bus.level;
        // A fresh event is consumed directly; otherwise replay a queued one.
        if (bus.evt || (pend_q != '0)) begin
          state_d  = ST_ON;
          led_n_d  = 1'b0;
          busy_d   = 1'b1;
          timer_d  = ON_LOAD;
          pend_dec = ~bus.evt;
        end
      end
      ST_ON: begin
        led_n_d  = 1'b0;
        pend_inc = bus.evt;
        if (timer_q != '0) begin
          timer_d = timer_q - CNT_WIDTH'(1);
        end else begin
          state_d = ST_OFF;
          led_n_d = 1'b1;
          timer_d = OFF_LOAD;
        end
      end
      ST_OFF: begin
        led_n_d  = 1'b1;
        pend_inc = bus.evt;
        if (timer_q != '0) begin
          timer_d = timer_q - CNT_WIDTH'(1);
        end else if (pend_q != '0) begin
          state_d  = ST_ON;
          led_n_d  = 1'b0;
          timer_d  = ON_LOAD;
          pend_dec = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          led_n_d = ~bus.level;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Simultaneous enqueue and dequeue cancel, so that path can never overflow.
    if (pend_inc && !pend_dec) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + PEND_WIDTH'(1);
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - PEND_WIDTH'(1);
    end
  end

  assign bus.led_n    = led_n_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_led_blink_driver.sv
// Randomized check of led_blink_driver against a blink-schedule model,
// with directed scenarios pinned by hand-computed expectations.
module tb_led_blink_driver;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int PW   = 2;
  localparam int CW   = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst, evt, level;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  led_blink_if #(.PEND_WIDTH(PW)) bus ();
  assign bus.evt   = evt;
  assign bus.level = level;

  led_blink_driver #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .CNT_WIDTH (CW),
    .PEND_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a blink started at edge s is lit after edges s..s+ON-1, dark through
  // s+ON+OFF-1, and edge s+ON+OFF either starts the next queued blink or idles.
  int m_n = 0, m_start = 0, m_pend = 0;
  bit m_active = 1'b0, m_ovf = 1'b0, m_led = 1'b1, m_busy = 1'b0;

  always @(posedge clk) begin
    bit ending, take;
    m_n++;
    if (rst) begin
      m_active = 1'b0;
      m_pend   = 0;
      m_ovf    = 1'b0;
    end else if (m_active) begin
      ending = (m_n - m_start) == ON + OFF;
      take   = ending && (m_pend > 0);
      if (evt && !take) begin
        if (m_pend == PMAX) m_ovf = 1'b1;
        else                m_pend++;
      end else if (take && !evt) begin
        m_pend--;
      end
      if (ending) begin
        if (take) m_start = m_n;
        else      m_active = 1'b0;
      end
    end else if (evt || (m_pend > 0)) begin
      m_active = 1'b1;
      m_start  = m_n;
      if (!evt) m_pend--;
    end
    if (m_active) begin
      m_led  = (m_n - m_start) >= ON;
      m_busy = 1'b1;
    end else begin
      m_led  = rst ? 1'b1 : !level;
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_led_n",    int'(bus.led_n),    int'(m_led));
      chk("model_busy",     int'(bus.busy),     int'(m_busy));
      chk("model_pending",  int'(bus.pending),  m_pend);
      chk("model_overflow", int'(bus.overflow), int'(m_ovf));
    end
  end

  // Per-test capture log: entry i holds the outputs i cycles after the first call.
  int led_log [64];
  int busy_log[64];
  int pend_log[64];
  int lidx = 0;
  int c_ovf;

  task automatic cyc(input logic e, input logic l, input logic r);
    @(negedge clk);
    c_ovf = int'(bus.overflow);
    if (lidx < 64) begin
      led_log[lidx]  = int'(bus.led_n);
      busy_log[lidx] = int'(bus.busy);
      pend_log[lidx] = int'(bus.pending);
      lidx++;
    end
    evt   = e;
    level = l;
    rst   = r;
  endtask

  function automatic int falls(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++)
      if (led_log[i] == 0 && led_log[i-1] == 1) n++;
    return n;
  endfunction

  initial begin
    logic [7:0] bits_led, bits_busy;
    int psum;
    logic e, lv, r;

    rst = 1'b1; evt = 1'b1; level = 1'b1;
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    chk_en = 1'b1;

    // Reset and release
    lidx = 0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_led_n",    led_log[1],  1);
    chk("rst_busy",     busy_log[1], 0);
    chk("rst_pending",  pend_log[1], 0);
    chk("rst_overflow", c_ovf,       0);

    // Single blink
    lidx = 0;
    cyc(1, 0, 0);
    repeat (8) cyc(0, 0, 0);
    psum = 0;
    for (int i = 1; i <= 8; i++) begin
      bits_led[i-1]  = led_log[i][0];
      bits_busy[i-1] = busy_log[i][0];
      psum += pend_log[i];
    end
    chk("single_led_seq",  int'(bits_led),  int'(8'b1111_0000));
    chk("single_busy_seq", int'(bits_busy), int'(8'b0111_1111));
    chk("single_pending",  psum, 0);

    // Two queued events replayed back to back
    lidx = 0;
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    repeat (20) cyc(0, 0, 0);
    chk("queue_pend_peak",   pend_log[4],  2);
    chk("queue_pend_blink2", pend_log[8],  1);
    chk("queue_pend_blink3", pend_log[15], 0);
    chk("queue_no_gap_off",  led_log[7],   1);
    chk("queue_no_gap_on",   led_log[8],   0);
    chk("queue_blinks",      falls(1, 23), 3);
    chk("queue_busy_last",   busy_log[21], 1);
    chk("queue_busy_done",   busy_log[22], 0);

    // Saturation and overflow
    lidx = 0;
    repeat (6) cyc(1, 0, 0);
    repeat (34) cyc(0, 0, 0);
    chk("sat_pend_max",   pend_log[4],  3);
    chk("sat_blinks",     falls(1, 39), 4);
    chk("sat_overflow",   c_ovf,        1);
    chk("sat_busy_end",   busy_log[39], 0);
    chk("sat_pend_end",   pend_log[39], 0);
    chk("sat_busy_last",  busy_log[28], 1);
    chk("sat_busy_idle",  busy_log[29], 0);
    cyc(0, 0, 1);
    lidx = 0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("ovf_cleared", c_ovf, 0);

    // Static level and blink over level
    lidx = 0;
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    repeat (8) cyc(0, 1, 0);
    chk("level_on", led_log[1], 0);
    for (int j = 1; j <= 8; j++) bits_led[j-1] = led_log[1+j][0];
    chk("level_blink_seq", int'(bits_led), int'(8'b0111_0000));
    repeat (2) cyc(0, 0, 0);

    // Reset mid-blink discards the queue
    lidx = 0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    repeat (16) cyc(0, 0, 0);
    chk("midrst_pend_before", pend_log[3], 2);
    chk("midrst_led_before",  led_log[3],  0);
    chk("midrst_led_n",       led_log[4],  1);
    chk("midrst_busy",        busy_log[4], 0);
    chk("midrst_pending",     pend_log[4], 0);
    chk("midrst_no_blinks",   falls(4, 19), 0);

    // Randomized traffic, checked every cycle against the model
    lv = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ((k / 200) % 2 == 0) e = ($urandom_range(0, 99) < 30);
      else                    e = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 49) == 0) lv = ~lv;
      r = ($urandom_range(0, 599) == 0);
      cyc(e, lv, r);
    end
    repeat (3) cyc(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
